// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: job sequencer in front of an external registered accumulator.
// A job of `len` operands clears the accumulator, streams the operands into it
// over a valid/ready handshake, then captures the final sum and a sticky carry
// flag. The result is held on a valid/ready output port until it is taken.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, len, abort     job control; start/len are sampled only when idle
//   busy                  high whenever a job is in flight
//   in_valid/in_data/in_ready    operand stream
//   acc_rst/acc_ce/acc_in        drive the accumulator's rst/ceAcu/in pins
//   acc_out                      accumulator output, fed back
//   res_valid/res_data/res_ovf/res_ready   result port
module acc_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             acc_rst,
  output logic             acc_ce,
  output logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] acc_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  input  logic             res_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_SETTLE, S_RESULT
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic             ovf;
  logic             beat;
  logic [WIDTH:0]   sum_ext;

  // Carry out of the accumulator's next add, observed one beat ahead.
  assign sum_ext = {1'b0, acc_out} + {1'b0, in_data};
  assign beat    = acc_ce;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort takes priority everywhere outside IDLE and also
  // blocks a start that arrives in the same idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_CLEAR;
      S_CLEAR:  if (abort)                state_nxt = S_IDLE;
                else if (rem != '0)       state_nxt = S_ACCUM;
                else                      state_nxt = S_SETTLE;
      S_ACCUM:  if (abort)                state_nxt = S_IDLE;
                else if (beat && rem == LEN_W'(1)) state_nxt = S_SETTLE;
      S_SETTLE: if (abort)                state_nxt = S_IDLE;
                else                      state_nxt = S_RESULT;
      S_RESULT: if (abort || res_ready)   state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // Outputs. in_ready is also dropped during rst so no operand is consumed
  // in a cycle whose state change is being discarded.
  always_comb begin
    busy      = (state != S_IDLE);
    in_ready  = (state == S_ACCUM) && !abort && !rst;
    acc_ce    = in_ready && in_valid;
    acc_in    = acc_ce ? in_data : '0;
    acc_rst   = rst || (state == S_CLEAR);
    res_valid = (state == S_RESULT);
  end

  // Job bookkeeping and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      ovf      <= 1'b0;
      res_data <= '0;
      res_ovf  <= 1'b0;
    end else begin
      if (state == S_IDLE && start && !abort) begin
        rem <= len;
        ovf <= 1'b0;
      end
      if (beat) begin
        rem <= rem - LEN_W'(1);
        ovf <= ovf | sum_ext[WIDTH];
      end
      // acc_out already includes the last beat by the SETTLE cycle.
      if (state == S_SETTLE && !abort) begin
        res_data <= acc_out;
        res_ovf  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
module tb_acc_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_valid, res_ready;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] in_data;
  logic             busy, in_ready, acc_rst, acc_ce, res_valid, res_ovf;
  logic [WIDTH-1:0] acc_in, acc_out, res_data;
  logic [WIDTH-1:0] acc_q;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] ops [16];
  bit               vpat [16];
  int               vpat_n = 0;

  always #5 clk = ~clk;

  acc_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .acc_rst(acc_rst), .acc_ce(acc_ce), .acc_in(acc_in), .acc_out(acc_out),
    .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
    .res_ready(res_ready)
  );

  // External accumulator the controller drives.
  always_ff @(posedge clk) begin
    if (acc_rst)     acc_q <= '0;
    else if (acc_ce) acc_q <= acc_q + acc_in;
  end
  assign acc_out = acc_q;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; in_valid = 0; in_data = '0; len = '0; res_ready = 0;
    tick(); tick();
    tests++;
    if ({busy, in_ready, acc_ce, res_valid, res_ovf} !== 5'b0 || acc_in !== '0 ||
        res_data !== '0 || acc_rst !== 1'b1) begin
      fails++;
      $display("FAIL reset: busy=%b rdy=%b ce=%b in=%0d rv=%b rd=%0d ro=%b arst=%b want all 0, arst=1",
               busy, in_ready, acc_ce, acc_in, res_valid, res_data, res_ovf, acc_rst);
    end
    rst = 1'b0;
    tick();
  endtask

  // Runs one job using ops[0..n-1]. Expected result comes from the integer
  // sum: wrapped value is the low WIDTH bits, and with non-negative operands
  // some beat carried out exactly when the true sum exceeds 2^WIDTH-1.
  task automatic run_job(input string name, input int n, input int vprob,
                         input int hold, input bit chk_lat);
    int sum = 0;
    int idx = 0;
    int cyc = 0;
    int guard = 0;
    int pi = 0;
    bit v;
    logic [WIDTH-1:0] exp_d;
    logic             exp_o;
    for (int i = 0; i < n; i++) sum += int'(ops[i]);
    exp_d = sum[WIDTH-1:0];
    exp_o = (sum > (1 << WIDTH) - 1);

    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL %s idle: busy=%b rdy=%b want 0 0", name, busy, in_ready);
    end
    start = 1'b1; len = LEN_W'(n);
    tick(); cyc = 1;
    start = 1'b0; len = LEN_W'($urandom);
    tests++;
    if (acc_rst !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || acc_ce !== 1'b0) begin
      fails++; $display("FAIL %s clear: arst=%b busy=%b rdy=%b ce=%b want 1 1 0 0",
                        name, acc_rst, busy, in_ready, acc_ce);
    end
    tick(); cyc = 2;

    while (idx < n && guard < 200) begin
      if (pi < vpat_n) begin v = vpat[pi]; pi++; end
      else v = ($urandom_range(99) < vprob);
      in_valid = v;
      in_data  = v ? ops[idx] : WIDTH'($urandom);
      start    = 1'($urandom_range(1));
      len      = LEN_W'($urandom);
      #1;
      tests++;
      if (in_ready !== 1'b1 || acc_ce !== v || acc_in !== (v ? ops[idx] : '0) || acc_rst !== 1'b0) begin
        fails++; $display("FAIL %s accum[%0d]: rdy=%b ce=%b in=%0d arst=%b want 1 %b %0d 0",
                          name, idx, in_ready, acc_ce, acc_in, acc_rst, v, v ? ops[idx] : '0);
      end
      if (v) idx++;
      tick(); cyc++; guard++;
    end
    if (guard >= 200) begin
      tests++; fails++; $display("FAIL %s beat budget expired: beats=%0d want %0d", name, idx, n);
    end
    in_valid = 1'b0; start = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1 || acc_ce !== 1'b0) begin
      fails++; $display("FAIL %s settle: rdy=%b rv=%b busy=%b ce=%b want 0 0 1 0",
                        name, in_ready, res_valid, busy, acc_ce);
    end
    tick(); cyc++;
    if (chk_lat) begin
      tests++;
      if (res_valid !== 1'b1 || cyc != 3 + n) begin
        fails++; $display("FAIL %s latency: rv=%b at cycle %0d want rv=1 at cycle %0d",
                          name, res_valid, cyc, 3 + n);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      res_ready = (h == hold);
      start     = (h < hold) ? 1'($urandom_range(1)) : 1'b0;
      #1;
      tests++;
      if (res_valid !== 1'b1 || res_data !== exp_d || res_ovf !== exp_o || busy !== 1'b1) begin
        fails++; $display("FAIL %s result[%0d]: rv=%b data=%0d ovf=%b busy=%b want 1 %0d %b 1",
                          name, h, res_valid, res_data, res_ovf, busy, exp_d, exp_o);
      end
      tick();
    end
    res_ready = 1'b0; start = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      fails++; $display("FAIL %s done: busy=%b rv=%b want 0 0", name, busy, res_valid);
    end
  endtask

  task automatic test_basic();
    ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30;
    run_job("basic", 3, 100, 0, 1'b1);
  endtask

  task automatic test_overflow();
    ops[0] = 8'd200; ops[1] = 8'd100;
    run_job("ovf_200_100", 2, 100, 0, 1'b1);
    ops[0] = 8'd255; ops[1] = 8'd1;
    run_job("ovf_255_1", 2, 100, 1, 1'b1);
  endtask

  task automatic test_len_zero();
    run_job("len0", 0, 100, 0, 1'b1);
  endtask

  task automatic test_stall_hold();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) vpat[i] = pat[i];
    vpat_n = 7;
    ops[0] = 8'd1; ops[1] = 8'd2; ops[2] = 8'd3; ops[3] = 8'd4;
    run_job("stall_hold", 4, 100, 5, 1'b0);
    vpat_n = 0;
  endtask

  task automatic test_abort();
    start = 1'b1; len = LEN_W'(3);
    tick(); start = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'd50;
    tick();
    abort = 1'b1; in_data = 8'd99;
    #1;
    tests++;
    if (in_ready !== 1'b0 || acc_ce !== 1'b0 || acc_in !== '0) begin
      fails++; $display("FAIL abort_cycle: rdy=%b ce=%b in=%0d want 0 0 0", in_ready, acc_ce, acc_in);
    end
    tick();
    abort = 1'b0; in_valid = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || acc_out !== 8'd50) begin
      fails++; $display("FAIL abort_idle: busy=%b acc=%0d want 0 50", busy, acc_out);
    end
    start = 1'b1; abort = 1'b1; len = LEN_W'(5);
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || acc_rst !== 1'b0) begin
      fails++; $display("FAIL abort_beats_start: busy=%b arst=%b want 0 0", busy, acc_rst);
    end
    ops[0] = 8'd7;
    run_job("after_abort", 1, 100, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    start = 1'b1; len = LEN_W'(4);
    tick(); start = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'd5; tick();
    in_data = 8'd6; tick();
    rst = 1'b1; in_data = 8'd9;
    #1;
    tests++;
    if (acc_rst !== 1'b1 || acc_ce !== 1'b0) begin
      fails++; $display("FAIL rst_cycle: arst=%b ce=%b want 1 0", acc_rst, acc_ce);
    end
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, in_ready, acc_ce, res_valid, res_ovf, acc_rst} !== 6'b0 ||
        acc_in !== '0 || res_data !== '0 || acc_out !== '0) begin
      fails++; $display("FAIL rst_after: busy=%b rdy=%b ce=%b rv=%b ro=%b arst=%b in=%0d rd=%0d acc=%0d want all 0",
                        busy, in_ready, acc_ce, res_valid, res_ovf, acc_rst, acc_in, res_data, acc_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (acc_ce !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL rst_quiet[%0d]: ce=%b rdy=%b want 0 0", i, acc_ce, in_ready);
      end
    end
    in_valid = 1'b0;
    ops[0] = 8'd3; ops[1] = 8'd4;
    run_job("after_rst", 2, 100, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 10; j++) begin
      int n = $urandom_range(15);
      for (int i = 0; i < n; i++) ops[i] = WIDTH'($urandom);
      run_job($sformatf("rand%0d", j), n, 70, $urandom_range(3), 1'b0);
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_len_zero();
    test_stall_hold();
    test_abort();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
Sequencer for the accumulator datapath. It accepts a job of LEN operands, clears the accumulator, and streams the operands into it over a valid/ready handshake. It then captures the final sum with a sticky overflow flag and holds the result on a valid/ready output port. It sits between the operand source and the accumulator and drives that block's rst/ceAcu/in pins.

Parameters:
WIDTH, 8, data width of operands, accumulator and result
LEN_W, 4, width of the job length field (max LEN = 2^LEN_W - 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  job request, sampled only in IDLE
len  input  LEN_W  operand count for the job, sampled with start
abort  input  1  cancels the current job, returns to IDLE
busy  output  1  high in any state other than IDLE
in_valid  input  1  operand valid
in_data  input  WIDTH  operand
in_ready  output  1  controller accepts an operand this cycle
acc_rst  output  1  to accumulator rst
acc_ce  output  1  to accumulator ceAcu
acc_in  output  WIDTH  to accumulator in
acc_out  input  WIDTH  from accumulator out
res_valid  output  1  result available
res_data  output  WIDTH  final sum, modulo 2^WIDTH
res_ovf  output  1  sum exceeded 2^WIDTH-1 at any beat
res_ready  input  1  result consumer ready

Behaviour:
- Accumulator contract, registered:
  - acc_rst=1 -> out=0 next edge.
  - acc_ce=1 -> out=out+in next edge, modulo 2^WIDTH.
- FSM states: IDLE, CLEAR, ACCUM, SETTLE, RESULT.
- IDLE:
  - busy=0, in_ready=0.
  - start=1 -> latch len into remaining counter; clear ovf; go to CLEAR.
- CLEAR:
  - acc_rst=1 for exactly one cycle.
  - Next state: ACCUM if remaining!=0, else SETTLE.
- ACCUM:
  - in_ready=1.
  - Each beat (in_valid&in_ready): acc_ce=1, acc_in=in_data, remaining-=1.
  - ovf |= carry-out of the (WIDTH+1)-bit sum acc_out+in_data.
  - Beat with remaining==1 -> SETTLE.
  - No beat -> acc_ce=0, state holds.
- SETTLE:
  - One cycle, in_ready=0.
  - res_data<=acc_out, res_ovf<=ovf; go to RESULT.
- RESULT:
  - res_valid=1; res_data and res_ovf stable.
  - res_valid&res_ready -> IDLE, res_valid=0 next cycle.
- acc_in is 0 whenever acc_ce=0. acc_ce is asserted only in ACCUM on a beat.
- Latency: start at cycle 0 -> CLEAR at 1 -> ACCUM from 2.
  - With N back-to-back beats, the last beat is at cycle 1+N, SETTLE at 2+N, res_valid at 3+N.
  - len=0: res_valid at cycle 3 with res_data=0, res_ovf=0.
- start while busy: ignored; len is not resampled.
- abort in any non-IDLE state:
  - Next state IDLE, no beat accepted that cycle (in_ready forced 0), res_valid drops.
  - The accumulator is not cleared by abort; the next job's CLEAR clears it.
- abort and start in the same IDLE cycle: abort wins, stay IDLE.
- rst, synchronous, in any state:
  - Next state IDLE, remaining=0, ovf=0, res_data=0, res_ovf=0.
  - acc_rst = rst | (state==CLEAR), so the accumulator is cleared on system reset.
- Reset values of outputs: busy=0, in_ready=0, acc_ce=0, acc_in=0, res_valid=0, res_data=0, res_ovf=0, acc_rst=1 while rst is held.
- Overflow is sticky for the job. Wrapped sums are reported, never saturated.

Test Plan:
- WIDTH=8, len=3, in 10,20,30 back-to-back, res_ready=1 -> acc_rst pulse at cycle 1; res_valid at cycle 6; res_data=60, res_ovf=0; busy low at cycle 7.
- len=2, in 200,100 -> res_data=44, res_ovf=1. Also len=2, in 255,1 -> res_data=0, res_ovf=1.
- len=0 -> CLEAR, SETTLE, RESULT; res_data=0, res_ovf=0 at cycle 3; in_ready never asserted.
- len=4, in_valid toggling 1,0,0,1,1,0,1, operands 1,2,3,4; res_ready held low 5 cycles -> res_data=10; res_valid and res_data stable throughout; start pulses during RESULT ignored.
- len=3, abort after 1 beat (data 50), then new job len=1, data 7 -> res_data=7 (CLEAR removes the stale 50), res_ovf=0.
- rst=1 for one cycle mid-ACCUM after 2 beats -> next cycle state IDLE, all outputs 0; acc_rst=1 during the reset cycle; no further acc_ce until a new start.
